bus_xcvr_ctrl: RTL and testbench



---
 rtl/bus_xcvr_ctrl_pkg.sv | 8 +
 rtl/bus_xcvr_ctrl_if.sv | 14 +
 rtl/bus_xcvr_ctrl.sv | 76 +++++++
 tb/tb_bus_xcvr_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/bus_xcvr_ctrl_pkg.sv
// bus_xcvr_pkg: command modes, FSM states and channel-index width helper for bus_xcvr_ctrl
package bus_xcvr_pkg;
  typedef enum logic [1:0] {M_NOP = 2'b00, M_LOOP = 2'b01, M_DRIVE = 2'b10, M_SAMPLE = 2'b11} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_e;
  function automatic int chw(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bus_xcvr_ctrl_if.sv
// bus_xcvr_ctrl_if: command handshake and channel data bundle
//   master (channel logic): cmd_valid, cmd_mode, cmd_ch, etod out; cmd_ready, dtoe, dtoe_valid, cmd_err in
//   slave  (transceiver):   the reverse
interface bus_xcvr_ctrl_if #(parameter int WIDTH = 4, parameter int NCH = 2);
  import bus_xcvr_pkg::*;
  localparam int CHW = chw(NCH);
  logic cmd_valid, cmd_ready, cmd_err;
  mode_e cmd_mode;
  logic [CHW-1:0] cmd_ch;
  logic [NCH*WIDTH-1:0] etod, dtoe;
  logic [NCH-1:0] dtoe_valid;
  modport master (output cmd_valid, cmd_mode, cmd_ch, etod, input cmd_ready, dtoe, dtoe_valid, cmd_err);
  modport slave (input cmd_valid, cmd_mode, cmd_ch, etod, output cmd_ready, dtoe, dtoe_valid, cmd_err);
endinterface

// File: rtl/bus_xcvr_ctrl.sv
// bus_xcvr_ctrl: handshaked transceiver between NCH channels and one shared tristate bus
//   clk, rst_n : clock, async active-low reset
//   c          : command handshake + channel data (slave side)
//   bus        : shared tristate bus, driven only in DRIVE state
//   bus_oe     : high while this block drives bus
module bus_xcvr_ctrl
  import bus_xcvr_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NCH       = 2,
  parameter int DRIVE_CYC = 1,
  parameter int TURN_CYC  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  bus_xcvr_ctrl_if.slave      c,
  inout  wire  [WIDTH-1:0]    bus,
  output logic                bus_oe
);
  localparam int CHW = chw(NCH);
  localparam int CW = $clog2((DRIVE_CYC > TURN_CYC ? DRIVE_CYC : TURN_CYC) + 1);
  localparam logic [CHW:0] NV = (CHW+1)'(NCH);
  localparam logic [CW-1:0] DLD = CW'(DRIVE_CYC - 1);
  localparam logic [CW-1:0] TLD = CW'(TURN_CYC - 1);
  state_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] drv_q, sel;
  logic acc, ok;
  assign c.cmd_ready = st_q == S_IDLE;
  assign acc = c.cmd_valid && c.cmd_ready;
  assign ok = {1'b0, c.cmd_ch} < NV;
  assign sel = c.etod[c.cmd_ch*WIDTH +: WIDTH];
  assign bus_oe = st_q == S_DRIVE;
  assign bus = bus_oe ? drv_q : {WIDTH{1'bz}};
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    case (st_q)
      S_IDLE: if (acc && ok && c.cmd_mode == M_DRIVE) begin
        st_d = S_DRIVE;
        cnt_d = DLD;
      end
      S_DRIVE: begin
        st_d = cnt_q == '0 ? S_TURN : S_DRIVE;
        cnt_d = cnt_q == '0 ? TLD : cnt_q - 1'b1;
      end
      S_TURN: begin
        st_d = cnt_q == '0 ? S_IDLE : S_TURN;
        cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
      end
      default: begin
        st_d = S_IDLE;
        cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= S_IDLE;
      cnt_q <= '0;
      drv_q <= '0;
      c.dtoe <= '0;
      c.dtoe_valid <= '0;
      c.cmd_err <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      c.dtoe_valid <= '0;
      c.cmd_err <= acc && !ok;
      if (acc && ok && (c.cmd_mode == M_LOOP || c.cmd_mode == M_SAMPLE)) begin
        c.dtoe[c.cmd_ch*WIDTH +: WIDTH] <= c.cmd_mode == M_LOOP ? sel : bus;
        c.dtoe_valid[c.cmd_ch] <= 1'b1;
      end
      if (acc && ok && c.cmd_mode == M_DRIVE) drv_q <= sel;
    end
endmodule

// File: tb/tb_bus_xcvr_ctrl.sv
// tb_bus_xcvr_ctrl: directed and random command sequences checked against a per-channel model
module tb_bus_xcvr_ctrl;
  import bus_xcvr_pkg::*;
  localparam int W = 4, N = 3, DC = 3, TC = 2;
  logic clk = 0, rst_n = 0, bus_oe, ext_en = 0;
  logic [W-1:0] ext = '0;
  wire [W-1:0] bus;
  logic [W-1:0] mdl [N];
  int npass = 0, ntot = 0;
  bus_xcvr_ctrl_if #(.WIDTH(W), .NCH(N)) bi();
  bus_xcvr_ctrl #(.WIDTH(W), .NCH(N), .DRIVE_CYC(DC), .TURN_CYC(TC)) dut (
    .clk(clk), .rst_n(rst_n), .c(bi), .bus(bus), .bus_oe(bus_oe));
  assign bus = ext_en ? ext : {W{1'bz}};
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask
  function automatic logic [N*W-1:0] mdl_packed();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = mdl[i];
    return r;
  endfunction
  task automatic chk_state(string tag, logic [N-1:0] dv, logic err);
    chk({tag, ".dtoe"}, 32'(bi.dtoe), 32'(mdl_packed()));
    chk({tag, ".dv"}, 32'(bi.dtoe_valid), 32'(dv));
    chk({tag, ".err"}, 32'(bi.cmd_err), 32'(err));
  endtask
  task automatic do_cmd(mode_e m, int ch, logic [W-1:0] d);
    logic ok;
    logic [N-1:0] dv;
    int n;
    string tag;
    tag = $sformatf("%s_ch%0d", m.name(), ch);
    ok = ch < N;
    dv = '0;
    bi.etod = (N*W)'($urandom);
    if (ok) bi.etod[ch*W +: W] = d;
    bi.cmd_valid = 1;
    bi.cmd_mode = m;
    bi.cmd_ch = ch[1:0];
    if (m == M_SAMPLE) begin
      ext_en = 1;
      ext = d;
    end
    if (m == M_DRIVE) ext_en = 0;
    n = 0;
    while (!bi.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".accept"}, 32'(n < 40), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (ok && (m == M_LOOP || m == M_SAMPLE)) begin
      mdl[ch] = d;
      dv[ch] = 1'b1;
    end
    if (m != M_DRIVE || !ok) bi.cmd_valid = 0;
    chk_state(tag, dv, !ok);
    chk({tag, ".rdy"}, 32'(bi.cmd_ready), (m == M_DRIVE && ok) ? 32'd0 : 32'd1);
    if (m == M_DRIVE && ok) begin
      bi.cmd_mode = M_SAMPLE;
      bi.cmd_ch = 2'd1;
      for (int i = 0; i < DC; i++) begin
        if (i > 0) chk_state("drive_hold", '0, 1'b0);
        chk("drive_oe", 32'(bus_oe), 32'd1);
        chk("drive_bus", 32'(bus), 32'(d));
        chk("drive_rdy", 32'(bi.cmd_ready), 32'd0);
        bi.etod = i == 0 ? {N{4'hF}} : (N*W)'($urandom);
        @(negedge clk);
      end
      for (int i = 0; i < TC; i++) begin
        chk_state("turn_hold", '0, 1'b0);
        chk("turn_oe", 32'(bus_oe), 32'd0);
        chk("turn_rdy", 32'(bi.cmd_ready), 32'd0);
        ext_en = 1;
        ext = W'($urandom);
        #1 chk("turn_bus", 32'(bus), 32'(ext));
        @(negedge clk);
      end
      chk("turn_done_rdy", 32'(bi.cmd_ready), 32'd1);
    end
  endtask
  initial begin
    mode_e m;
    int ch;
    bi.cmd_valid = 0;
    bi.cmd_mode = M_NOP;
    bi.cmd_ch = '0;
    bi.etod = '0;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_oe", 32'(bus_oe), 32'd0);
    chk_state("reset", '0, 1'b0);
    rst_n = 1;
    @(negedge clk);
    chk("reset_rdy", 32'(bi.cmd_ready), 32'd1);
    do_cmd(M_LOOP, 1, 4'hA);
    do_cmd(M_NOP, 0, 4'h0);
    do_cmd(M_DRIVE, 0, 4'h5);
    do_cmd(M_SAMPLE, 1, 4'h3);
    chk("sample_oe", 32'(bus_oe), 32'd0);
    do_cmd(M_LOOP, 3, 4'h7);
    do_cmd(M_NOP, 0, 4'h0);
    do_cmd(M_LOOP, 0, 4'h6);
    do_cmd(M_LOOP, 1, 4'h9);
    ext_en = 0;
    bi.etod = 12'h123;
    bi.cmd_mode = M_DRIVE;
    bi.cmd_ch = 2'd2;
    bi.cmd_valid = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_oe_before", 32'(bus_oe), 32'd1);
    chk("rst_mid_bus_before", 32'(bus), 32'h1);
    #2 rst_n = 0;
    #1 chk("rst_mid_oe", 32'(bus_oe), 32'd0);
    ext_en = 1;
    ext = 4'hA;
    #1 chk("rst_mid_bus", 32'(bus), 32'hA);
    for (int i = 0; i < N; i++) mdl[i] = '0;
    chk_state("rst_mid", '0, 1'b0);
    bi.cmd_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_mid_rdy", 32'(bi.cmd_ready), 32'd1);
    for (int k = 0; k < 150; k++) begin
      m = mode_e'($urandom_range(0, 3));
      ch = $urandom_range(0, 3);
      do_cmd(m, ch, W'($urandom));
      if (m == M_DRIVE && ch < N) do_cmd(M_SAMPLE, 1, W'($urandom));
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
